// File: rtl/b2asc_pkg.sv
// Shared constants, state encoding and parameter helpers for the
// binary-to-ASCII stream formatter.
package b2asc_pkg;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_SIGN,
      S_DIG,
      S_CR,
      S_LF
   } state_e;

   // Decimal digits needed to print the largest unsigned value of 'width' bits.
   function automatic int dec_digits(input int width);
      longint unsigned v;
      int              n;
      v = (64'd1 << width) - 64'd1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/b2asc_stream_nib2asc.sv
// Maps one 4-bit digit to its ASCII character: 0-9 then uppercase A-F.
module nib2asc
   import b2asc_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [7:0] asc_o
);

   always_comb begin
      if (nib_i < 4'd10) asc_o = ASCII_0 + {4'd0, nib_i};
      else               asc_o = ASCII_A + {4'd0, nib_i} - 8'd10;
   end

endmodule

// File: rtl/b2asc_stream.sv
// Binary-to-ASCII formatter: converts one result to decimal or hex and
// streams the characters (optionally followed by CR LF) over ready/valid.
module b2asc_stream
   import b2asc_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DIGITS      = 5,
   parameter int SIGNED      = 1,
   parameter int APPEND_CRLF = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_hex,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_last,
   output logic              busy
);

   localparam int NHEX  = DATA_W / 4;
   localparam int NDIG  = (DIGITS > NHEX) ? DIGITS : NHEX;
   localparam int DBITS = 4 * NDIG;
   localparam int PTR_W = $clog2(NDIG + 1);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [PTR_W-1:0] HEX_TOP = PTR_W'(NHEX - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
   localparam logic             CRLF    = (APPEND_CRLF != 0);

   if (DATA_W % 4 != 0) begin : g_chk_width
      $error("b2asc_stream: DATA_W must be a multiple of 4");
   end
   if (DIGITS < dec_digits(DATA_W)) begin : g_chk_digits
      $error("b2asc_stream: DIGITS too small for DATA_W");
   end

   state_e             state_q;
   logic [DATA_W-1:0]  bin_q;
   logic [DBITS-1:0]   dig_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PTR_W-1:0]   ptr_q;
   logic               neg_q;
   logic               hex_q;
   logic               tx_valid_q;
   logic [7:0]         tx_data_q;
   logic               tx_last_q;

   logic [DBITS-1:0]   dig_adj;
   logic [DBITS-1:0]   conv_dig_d;
   logic [PTR_W-1:0]   conv_ptr_d;
   logic [PTR_W-1:0]   ptr_dn;
   logic               conv_done;
   logic [3:0]         nib_sel;
   logic [7:0]         nib_asc;

   function automatic logic [DBITS-1:0] add3(input logic [DBITS-1:0] d);
      logic [DBITS-1:0] r;
      r = d;
      for (int i = 0; i < NDIG; i++) begin
         if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Next digit register during CONV, and the most significant non-zero
   // digit of it (leading-zero pointer), which is where emission starts.
   always_comb begin
      dig_adj    = add3(dig_q);
      conv_dig_d = hex_q ? DBITS'(bin_q)
                         : ((dig_adj << 1) | DBITS'(bin_q[DATA_W-1]));
      conv_ptr_d = '0;
      if (hex_q) begin
         conv_ptr_d = HEX_TOP;
      end else begin
         for (int i = 0; i < NDIG; i++) begin
            if (conv_dig_d[4*i +: 4] != 4'd0) conv_ptr_d = PTR_W'(i);
         end
      end
      conv_done = hex_q || (cnt_q == '0);
      ptr_dn    = ptr_q - PTR_W'(1);
      case (state_q)
         S_CONV:  nib_sel = 4'(conv_dig_d >> (4 * conv_ptr_d));
         S_SIGN:  nib_sel = 4'(dig_q >> (4 * ptr_q));
         default: nib_sel = 4'(dig_q >> (4 * ptr_dn));
      endcase
   end

   nib2asc u_nib2asc (
      .nib_i (nib_sel),
      .asc_o (nib_asc)
   );

   // The state names the byte currently presented on tx_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         dig_q      <= '0;
         cnt_q      <= '0;
         ptr_q      <= '0;
         neg_q      <= 1'b0;
         hex_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_valid_q <= 1'b0;
               tx_last_q  <= 1'b0;
               if (in_valid) begin
                  hex_q   <= in_hex;
                  cnt_q   <= CNT_TOP;
                  dig_q   <= '0;
                  state_q <= S_CONV;
                  if ((SIGNED != 0) && !in_hex && in_data[DATA_W-1]) begin
                     neg_q <= 1'b1;
                     bin_q <= -in_data;
                  end else begin
                     neg_q <= 1'b0;
                     bin_q <= in_data;
                  end
               end
            end
            S_CONV: begin
               dig_q <= conv_dig_d;
               bin_q <= bin_q << 1;
               cnt_q <= cnt_q - CNT_W'(1);
               if (conv_done) begin
                  ptr_q      <= conv_ptr_d;
                  tx_valid_q <= 1'b1;
                  if (neg_q) begin
                     state_q   <= S_SIGN;
                     tx_data_q <= ASCII_MINUS;
                     tx_last_q <= 1'b0;
                  end else begin
                     state_q   <= S_DIG;
                     tx_data_q <= nib_asc;
                     tx_last_q <= !CRLF && (conv_ptr_d == '0);
                  end
               end
            end
            S_SIGN: begin
               if (tx_ready) begin
                  state_q   <= S_DIG;
                  tx_data_q <= nib_asc;
                  tx_last_q <= !CRLF && (ptr_q == '0);
               end
            end
            S_DIG: begin
               if (tx_ready) begin
                  if (ptr_q != '0) begin
                     ptr_q     <= ptr_dn;
                     tx_data_q <= nib_asc;
                     tx_last_q <= !CRLF && (ptr_dn == '0);
                  end else if (CRLF) begin
                     state_q   <= S_CR;
                     tx_data_q <= ASCII_CR;
                     tx_last_q <= 1'b0;
                  end else begin
                     state_q    <= S_IDLE;
                     tx_valid_q <= 1'b0;
                     tx_data_q  <= 8'h00;
                     tx_last_q  <= 1'b0;
                  end
               end
            end
            S_CR: begin
               if (tx_ready) begin
                  state_q   <= S_LF;
                  tx_data_q <= ASCII_LF;
                  tx_last_q <= 1'b1;
               end
            end
            S_LF: begin
               if (tx_ready) begin
                  state_q    <= S_IDLE;
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= 8'h00;
                  tx_last_q  <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               tx_valid_q <= 1'b0;
               tx_data_q  <= 8'h00;
               tx_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign tx_last  = tx_last_q;

endmodule

// File: tb/tb_b2asc_stream.sv
// Bench for b2asc_stream: two instances (signed+CRLF, unsigned without CRLF)
// fed identical requests and checked against a string-level model.
module tb_b2asc_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_hex;
   logic        tx_ready;
   logic        ir [2];
   logic        tv [2];
   logic [7:0]  td [2];
   logic        tl [2];
   logic        bz [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rdy_rand = 0;
   bit noise    = 0;

   b2asc_stream #(.DATA_W(16), .DIGITS(5), .SIGNED(1), .APPEND_CRLF(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .in_data(in_data), .in_hex(in_hex), .tx_valid(tv[0]), .tx_ready(tx_ready),
      .tx_data(td[0]), .tx_last(tl[0]), .busy(bz[0]));

   b2asc_stream #(.DATA_W(16), .DIGITS(5), .SIGNED(0), .APPEND_CRLF(0)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .in_data(in_data), .in_hex(in_hex), .tx_valid(tv[1]), .tx_ready(tx_ready),
      .tx_data(td[1]), .tx_last(tl[1]), .busy(bz[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: the exact text a UART terminal should show.
   function automatic string exp_str(input logic [15:0] v, input bit hx,
                                     input bit sg, input bit cr);
      string s;
      int    n;
      s = "";
      if (hx) begin
         for (int i = 3; i >= 0; i--) begin
            n = int'((v >> (4 * i)) & 16'hF);
            s = $sformatf("%s%c", s, (n < 10) ? (8'h30 + n) : (8'h41 + n - 10));
         end
      end else if (sg) begin
         s = $sformatf("%0d", int'($signed(v)));
      end else begin
         s = $sformatf("%0d", int'(v));
      end
      if (cr) s = $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
      return s;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam bit SG = (g == 0);
      logic [7:0] q   [$];
      logic [7:0] cap [$];
      logic       pv = 0, px = 0, pl = 0;
      logic [7:0] pd = 0;
      bit         wait_first = 0;
      int         acc_c = 0;
      int         lat = 0;
      string      s;

      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            wait_first = 0;
            pv = 0;
            px = 0;
         end else begin
            chk($sformatf("d%0d_in_ready", g), ir[g], q.size() == 0);
            chk($sformatf("d%0d_busy", g), bz[g], q.size() != 0);
            if (pv && !px) begin
               chk($sformatf("d%0d_stall_valid", g), tv[g], 1);
               chk($sformatf("d%0d_stall_data", g), td[g], pd);
               chk($sformatf("d%0d_stall_last", g), tl[g], pl);
            end
            if (px && q.size() > 0) chk($sformatf("d%0d_bubble", g), tv[g], 1);
            if (tv[g]) begin
               if (q.size() == 0) begin
                  chk($sformatf("d%0d_spurious_valid", g), tv[g], 0);
               end else begin
                  if (wait_first) begin
                     chk($sformatf("d%0d_latency", g), cyc - acc_c, lat);
                     wait_first = 0;
                  end
                  chk($sformatf("d%0d_data", g), td[g], q[0]);
                  chk($sformatf("d%0d_last", g), tl[g], q.size() == 1);
                  if (tx_ready) begin
                     cap.push_back(td[g]);
                     void'(q.pop_front());
                  end
               end
            end
            pv = tv[g];
            pd = td[g];
            pl = tl[g];
            px = tv[g] && tx_ready;
            if (in_valid && ir[g]) begin
               s = exp_str(in_data, in_hex, SG, SG);
               for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
               acc_c      = cyc;
               wait_first = 1;
               lat        = in_hex ? 2 : 17;
            end
         end
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string nm);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s_d%0d_tx_valid", nm, g), tv[g], 0);
         chk($sformatf("%s_d%0d_tx_data", nm, g), td[g], 0);
         chk($sformatf("%s_d%0d_tx_last", nm, g), tl[g], 0);
         chk($sformatf("%s_d%0d_busy", nm, g), bz[g], 0);
         chk($sformatf("%s_d%0d_in_ready", nm, g), ir[g], 1);
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(posedge clk);
         #1;
         if (ir[0] && ir[1]) begin
            done     = 1;
            in_valid = 1'b0;
         end else if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            in_hex   = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
      end
      if (!done) chk("idle_timeout", 0, 1);
   endtask

   task automatic send(input logic [15:0] v, input bit hx);
      wait_idle();
      in_valid = 1'b1;
      in_data  = v;
      in_hex   = hx;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_cap(input string nm, input string lit0, input string lit1);
      string e0;
      e0 = $sformatf("%s%c%c", lit0, 8'h0D, 8'h0A);
      chk({nm, "_len0"}, g_mon[0].cap.size(), e0.len());
      for (int i = 0; i < e0.len() && i < g_mon[0].cap.size(); i++)
         chk($sformatf("%s_d0_byte%0d", nm, i), g_mon[0].cap[i], e0[i]);
      chk({nm, "_len1"}, g_mon[1].cap.size(), lit1.len());
      for (int i = 0; i < lit1.len() && i < g_mon[1].cap.size(); i++)
         chk($sformatf("%s_d1_byte%0d", nm, i), g_mon[1].cap[i], lit1[i]);
      g_mon[0].cap.delete();
      g_mon[1].cap.delete();
   endtask

   initial begin
      bit found;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_hex   = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      send(16'd0, 0);       wait_idle(); check_cap("zero", "0", "0");
      send(16'd1234, 0);    wait_idle(); check_cap("dec1234", "1234", "1234");
      send(16'h8000, 0);    wait_idle(); check_cap("min_neg", "-32768", "32768");
      send(16'hFFFF, 0);    wait_idle(); check_cap("all_ones", "-1", "65535");
      send(16'h0A5F, 1);    wait_idle(); check_cap("hex0A5F", "0A5F", "0A5F");
      send(16'd9, 0);       wait_idle(); check_cap("one_digit", "9", "9");

      rdy_rand = 1;
      noise    = 1;
      for (int n = 0; n < 40; n++) begin
         case (n % 8)
            0:       send(16'h8000, 0);
            1:       send(16'h7FFF, 0);
            2:       send(16'd0, 1);
            3:       send(16'd10, 0);
            default: send(16'($urandom), 1'($urandom_range(0, 1)));
         endcase
      end
      wait_idle();
      noise = 0;
      g_mon[0].cap.delete();
      g_mon[1].cap.delete();

      rdy_rand = 0;
      send(16'd1234, 0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk);
         #1;
         if (tv[0] && td[0] == 8'h33) found = 1;
      end
      chk("reach_third_digit", found, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      g_mon[0].cap.delete();
      g_mon[1].cap.delete();
      send(16'd7, 0);       wait_idle(); check_cap("after_reset", "7", "7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/b2asc_stream.md
# b2asc_stream

Sequential binary-to-ASCII formatter between the ALU result register and the UART transmitter. It accepts one `DATA_W`-bit result per handshake and converts it to decimal (signed or unsigned) or fixed-width hexadecimal. It then streams the ASCII characters, optionally terminated by CR LF, one byte per ready/valid handshake into the UART TX byte input.

## Interface
- `DATA_W`, default 16: result width; must be a multiple of 4.
- `DIGITS`, default 5: decimal digit capacity; must satisfy 10^DIGITS ≥ 2^DATA_W.
- `SIGNED`, default 1: 1 means decimal mode treats `in_data` as two's complement.
- `APPEND_CRLF`, default 1: 1 means append 0x0D, 0x0A after the last digit.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block idle and able to accept a request.
- `in_data`  in  DATA_W  value to format.
- `in_hex`  in  1  sampled with `in_data`: 1 selects hex, 0 selects decimal.
- `tx_valid`  out  1  `tx_data` holds a valid character.
- `tx_ready`  in  1  UART TX accepts the byte this cycle.
- `tx_data`  out  8  ASCII character.
- `tx_last`  out  1  marks the final byte of the string.
- `busy`  out  1  high from request accept until the last byte is accepted.

## Operation
- **States:** IDLE, CONV, SIGN, DIG, CR, LF.
- **IDLE:**
  - `in_ready` is 1.
  - On `in_valid && in_ready`, latch `in_data` and `in_hex`, then go to CONV.
- **Decimal CONV (double-dabble):**
  - If `SIGNED` and `in_data[DATA_W-1]` is set, the block sets a neg flag and converts the magnitude −x as unsigned `DATA_W` bits. For DATA_W=16, 0x8000 yields magnitude 32768.
  - The conversion runs one shift per cycle, with add-3 applied to every BCD nibble ≥ 5 before each shift, for `DATA_W` cycles.
- **Hex CONV:**
  - Takes 1 cycle and loads the DATA_W/4 nibbles directly.
  - Sign handling is never applied in hex mode.
- **After CONV:**
  - Go to SIGN if neg is set, otherwise go to DIG.
  - SIGN emits 0x2D ('-').
- **DIG:**
  - Emits digits MS first.
  - Decimal suppresses leading zeros but always emits at least one digit; a zero value emits "0".
  - Hex emits all DATA_W/4 nibbles, including leading zeros.
  - Digit mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- **After the last digit:**
  - If `APPEND_CRLF`, go to CR (0x0D), then LF (0x0A).
  - Otherwise return to IDLE.
- **`tx_last`:** set on the LF byte, or on the last digit when `APPEND_CRLF`=0.
- **Illegal or unreachable state:** return to IDLE.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0x00, `tx_last`=0, `busy`=0, `in_ready`=1; state is IDLE; the digit register is cleared.
- **Mid-operation reset:** asserting `rst_n` at any point aborts the string immediately. No partial byte is presented after release.
- **Latency:** request accepted on edge k.
  - Decimal: CONV spans cycles k+1..k+DATA_W, and the first `tx_valid` is high in cycle k+DATA_W+1.
  - Hex: the first `tx_valid` is high in cycle k+2.
- **Handshake:**
  - A byte transfers on `tx_valid && tx_ready`.
  - While `tx_valid && !tx_ready`, `tx_data` and `tx_last` hold stable.
  - `tx_valid` never drops without a transfer.
- **Throughput:** with `tx_ready` held at 1, one byte is emitted per cycle and there are no bubbles between bytes.
- **Return to IDLE:** after the byte with `tx_last` transfers, the state returns to IDLE and `in_ready` rises in the next cycle. Accept-to-accept spacing is ≥ 1 idle cycle.
- **Requests while busy:** `in_valid` during busy is ignored; `in_ready` is 0 while busy.

## Structure
- **Package `b2asc_pkg`:**
  - ASCII constants: ASCII_0=0x30, ASCII_A=0x41, ASCII_MINUS=0x2D, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - The state enum.
  - A function returning the required decimal digit count for a width, used for a parameter legality check.
- **Sub-module `nib2asc`:** combinational 4-bit-to-ASCII map covering 0–9 and A–F, shared by the decimal and hex paths.
- **Inline logic:** the double-dabble add-3 stage and the leading-zero pointer stay in the top level.

## Test plan
- Decimal, unsigned value 0 with `tx_ready`=1 → "0",0x0D,0x0A; `tx_last` set only on 0x0A; first byte at k+17.
- Decimal 16'd1234 → 0x31,0x32,0x33,0x34,0x0D,0x0A, with no bubbles between bytes.
- Signed decimal 16'h8000 → "-32768\r\n"; 16'hFFFF → "-1\r\n"; with `SIGNED`=0, 16'hFFFF → "65535\r\n".
- Hex, `in_hex`=1, 16'h0A5F → 0x30,0x41,0x35,0x46,0x0D,0x0A; first byte at k+2.
- Backpressure: `tx_ready` toggled pseudo-randomly → byte sequence unchanged, `tx_data` stable while stalled, `in_valid` pulses during busy ignored.
- `rst_n` asserted during the third digit of "1234" → all outputs reach reset values immediately; a new request of 7 then yields exactly "7\r\n".
